// File: rtl/spi_codec_pkg.sv
// Shared definitions for the codec boot sequencer: FSM states, word width
// and WM8731-style control register addresses.
package spi_codec_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SEND_HI = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_SEND_LO = 3'd4,
        ST_WAIT_LO = 3'd5,
        ST_GAP     = 3'd6
    } state_t;

    localparam logic [6:0] REG_LINVOL = 7'h00;
    localparam logic [6:0] REG_RINVOL = 7'h01;
    localparam logic [6:0] REG_LHPOUT = 7'h02;
    localparam logic [6:0] REG_RHPOUT = 7'h03;
    localparam logic [6:0] REG_APANA  = 7'h04;
    localparam logic [6:0] REG_DPATH  = 7'h05;
    localparam logic [6:0] REG_PWR    = 7'h06;
    localparam logic [6:0] REG_DAIF   = 7'h07;
    localparam logic [6:0] REG_SRATE  = 7'h08;
    localparam logic [6:0] REG_ACTIVE = 7'h09;
    localparam logic [6:0] REG_RESET  = 7'h0F;

    function automatic logic [WORD_W-1:0] codec_word(input logic [6:0] addr,
                                                     input logic [8:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/spi_codec_cfg_rom.sv
// Boot configuration table: index -> 16-bit codec control word.
// Indices at or beyond N_CFG read as zero.
module spi_codec_cfg_rom
    import spi_codec_pkg::*;
#(
    parameter int N_CFG = 10
) (
    input  logic [5:0]        i_index,
    output logic [WORD_W-1:0] o_word
);

    localparam logic [6:0] N_LIM = 7'(N_CFG);

    logic [WORD_W-1:0] w_entry;

    always_comb begin
        w_entry = codec_word(REG_ACTIVE, 9'h001);
        case (i_index)
            6'd0:    w_entry = codec_word(REG_RESET,  9'h000);
            6'd1:    w_entry = codec_word(REG_PWR,    9'h000);
            6'd2:    w_entry = codec_word(REG_LINVOL, 9'h017);
            6'd3:    w_entry = codec_word(REG_RINVOL, 9'h017);
            6'd4:    w_entry = codec_word(REG_LHPOUT, 9'h079);
            6'd5:    w_entry = codec_word(REG_RHPOUT, 9'h079);
            6'd6:    w_entry = codec_word(REG_APANA,  9'h012);
            6'd7:    w_entry = codec_word(REG_DPATH,  9'h000);
            6'd8:    w_entry = codec_word(REG_DAIF,   9'h00A);
            6'd9:    w_entry = codec_word(REG_ACTIVE, 9'h001);
            default: w_entry = codec_word(REG_ACTIVE, 9'h001);
        endcase
    end

    assign o_word = ({1'b0, i_index} < N_LIM) ? w_entry : '0;

endmodule

// File: rtl/spi_codec_sequencer.sv
// Streams the boot table (and later single runtime writes) to an external
// SPI byte engine as {addr,data} words, high byte first, with a recovery gap.
module spi_codec_sequencer
    import spi_codec_pkg::*;
#(
    parameter int N_CFG      = 10,
    parameter int GAP_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_wr_req,
    input  logic [6:0] i_wr_addr,
    input  logic [8:0] i_wr_data,
    output logic       o_wr_ack,
    output logic [7:0] o_data,
    output logic       o_trg,
    input  logic       i_rdy,
    output logic       o_busy,
    output logic       o_done,
    output state_t     o_state
);

    localparam logic [5:0] LAST_IDX = 6'(N_CFG - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_src_rt;
    logic [5:0]        r_idx;
    logic [7:0]        r_gap;
    logic [WORD_W-1:0] r_word;
    logic [7:0]        r_data;
    logic              r_wr_ack;
    logic              r_done;
    logic              r_wait_first;

    logic [WORD_W-1:0] w_rom_word;
    logic [WORD_W-1:0] w_src_word;
    logic              w_trg;
    logic              w_wait_go;
    logic              w_gap_end;

    spi_codec_cfg_rom #(.N_CFG(N_CFG)) u_rom (
        .i_index (r_idx),
        .o_word  (w_rom_word)
    );

    assign w_src_word = r_src_rt ? {i_wr_addr, i_wr_data} : w_rom_word;
    // The engine drops RDY only after seeing TRG, so the first WAIT cycle is blind.
    assign w_wait_go  = !r_wait_first && i_rdy;
    assign w_gap_end  = (r_gap == GAP_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_trg  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start)                 w_next = ST_LOAD;
                else if (i_wr_req && r_done) w_next = ST_LOAD;
            end
            ST_LOAD:    if (i_rdy) w_next = ST_SEND_HI;
            ST_SEND_HI: begin
                w_trg  = 1'b1;
                w_next = ST_WAIT_HI;
            end
            ST_WAIT_HI: if (w_wait_go) w_next = ST_SEND_LO;
            ST_SEND_LO: begin
                w_trg  = 1'b1;
                w_next = ST_WAIT_LO;
            end
            ST_WAIT_LO: if (w_wait_go) w_next = ST_GAP;
            ST_GAP: begin
                if (w_gap_end) begin
                    if (!r_src_rt && r_idx != LAST_IDX) w_next = ST_LOAD;
                    else                                w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_src_rt     <= 1'b0;
            r_idx        <= '0;
            r_gap        <= '0;
            r_word       <= '0;
            r_data       <= '0;
            r_wr_ack     <= 1'b0;
            r_done       <= 1'b0;
            r_wait_first <= 1'b0;
        end else begin
            r_wr_ack     <= 1'b0;
            r_wait_first <= w_trg;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_src_rt <= 1'b0;
                        r_idx    <= '0;
                        r_done   <= 1'b0;
                    end else if (i_wr_req && r_done) begin
                        r_src_rt <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_word <= w_src_word;
                    if (i_rdy) r_data <= w_src_word[15:8];
                end
                ST_WAIT_HI: if (w_wait_go) r_data <= r_word[7:0];
                ST_WAIT_LO: if (w_wait_go) r_gap <= '0;
                ST_GAP: begin
                    if (!w_gap_end) begin
                        r_gap <= r_gap + 8'd1;
                    end else if (r_src_rt) begin
                        r_wr_ack <= 1'b1;
                    end else if (r_idx == LAST_IDX) begin
                        r_done <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_trg    = w_trg;
    assign o_data   = r_data;
    assign o_wr_ack = r_wr_ack;
    assign o_done   = r_done;
    assign o_busy   = (r_state != ST_IDLE);
    assign o_state  = r_state;

endmodule
